// File: rtl/prog_mem_writer_if.sv
// Port bundles for the boot-programmer write adapter: the 128-bit line write
// port and the narrow 32-bit memory beat port.
interface pmw_line_if;
    logic         in_req;
    logic         in_gnt;
    logic         in_we;
    logic [31:0]  in_addr;
    logic [127:0] in_wdata;
    logic [15:0]  in_wstrb;

    modport master (output in_req, in_we, in_addr, in_wdata, in_wstrb, input in_gnt);
    modport slave  (input in_req, in_we, in_addr, in_wdata, in_wstrb, output in_gnt);
endinterface

interface pmw_mem_if;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, input mem_gnt);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, output mem_gnt);
endinterface

// File: rtl/prog_mem_writer.sv
// Buffers 128-bit line writes in a FIFO and drains each line as up to four
// 32-bit beats, skipping words whose strobe nibble is zero.
//
// state  | meaning
// IDLE   | waiting for a FIFO entry; pops all-zero-strobe lines directly
// ISSUE  | presenting beat k of the head line until mem_gnt
module prog_mem_writer #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    pmw_line_if.slave   line,
    pmw_mem_if.master   mem,
    output logic        busy,
    output logic        overflow,
    output logic [31:0] words_written
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    logic [31:0]  addr_q [FIFO_DEPTH];
    logic [127:0] data_q [FIFO_DEPTH];
    logic [15:0]  strb_q [FIFO_DEPTH];
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic         overflow_q;
    logic [31:0]  words_q;
    state_t       state_q, state_d;
    logic [1:0]   k_q, k_d;

    logic         empty, full, push, drop, pop;
    logic [AW-1:0] rd_idx;
    logic [31:0]  head_addr;
    logic [127:0] head_data;
    logic [15:0]  head_strb;
    logic [2:0]   first_nz, next_nz;

    // Returns {found, index} of the lowest non-zero strobe nibble at or above 'from'.
    function automatic logic [2:0] find_nz(input logic [15:0] s, input logic [2:0] from);
        logic [2:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (i >= int'(from) && s[4*i +: 4] != 4'h0) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    assign rd_idx    = rd_ptr_q[AW-1:0];
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push      = line.in_req && line.in_we && !full;
    assign drop      = line.in_req && line.in_we && full;
    assign head_addr = addr_q[rd_idx];
    assign head_data = data_q[rd_idx];
    assign head_strb = strb_q[rd_idx];
    assign first_nz  = find_nz(head_strb, 3'd0);
    assign next_nz   = find_nz(head_strb, {1'b0, k_q} + 3'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    if (first_nz[2]) begin
                        state_d = S_ISSUE;
                        k_d     = first_nz[1:0];
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (mem.mem_gnt) begin
                    if (next_nz[2]) begin
                        k_d = next_nz[1:0];
                    end else begin
                        pop     = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem.mem_req   = (state_q == S_ISSUE);
        mem.mem_we    = 1'b1;
        mem.mem_addr  = head_addr + {28'h0, k_q, 2'b00};
        mem.mem_wdata = head_data[32*k_q +: 32];
        mem.mem_wstrb = head_strb[4*k_q +: 4];
        line.in_gnt   = !full;
        busy          = !empty || (state_q != S_IDLE);
    end

    // Entry storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            addr_q[wr_ptr_q[AW-1:0]] <= ADDR_BASE + (line.in_addr & 32'hFFFF_FFF0);
            data_q[wr_ptr_q[AW-1:0]] <= line.in_wdata;
            strb_q[wr_ptr_q[AW-1:0]] <= line.in_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            words_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                words_q  <= words_q + 32'd1;
            end
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign overflow      = overflow_q;
    assign words_written = words_q;
endmodule

// File: tb/tb_prog_mem_writer.sv
// Self-checking bench for prog_mem_writer: vector table, directed sequences
// and randomized traffic against a line/beat queue reference model.
module tb_prog_mem_writer;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] TB_BASE = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        busy, overflow;
    logic [31:0] words_written;
    int          total, bad;

    pmw_line_if li ();
    pmw_mem_if  mi ();

    prog_mem_writer #(.FIFO_DEPTH(DEPTH), .ADDR_BASE(TB_BASE)) dut (
        .clk(clk), .rst_n(rst_n), .line(li), .mem(mi),
        .busy(busy), .overflow(overflow), .words_written(words_written)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: expected beats in issue order, line occupancy, counters.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          occ;
    int          beats_done;
    logic [31:0] exp_words;
    logic        exp_ovf;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        occ        = 0;
        beats_done = 0;
        exp_words  = '0;
        exp_ovf    = 1'b0;
    endfunction

    // A line turns into one beat per non-zero nibble, lowest word first.
    function automatic void model_push(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
        logic [31:0] base;
        int          lastk;
        beat_t       b;
        base  = TB_BASE + a - (a % 16);
        lastk = -1;
        for (int k = 0; k < 4; k++) if (s[4*k +: 4] != 4'h0) lastk = k;
        for (int k = 0; k < 4; k++) begin
            if (s[4*k +: 4] != 4'h0) begin
                b.a    = base + 32'(4 * k);
                b.d    = d[32*k +: 32];
                b.s    = s[4*k +: 4];
                b.last = (k == lastk);
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic set_idle();
        li.in_req   = 1'b0;
        li.in_we    = 1'b0;
        li.in_addr  = '0;
        li.in_wdata = '0;
        li.in_wstrb = '0;
    endtask

    task automatic reset_dut();
        set_idle();
        mi.mem_gnt = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    // One clock of stimulus, called at a negedge; checks, then advances the model at the edge.
    task automatic cyc(input logic req, input logic we, input logic [31:0] a,
                       input logic [127:0] d, input logic [15:0] s, input logic gnt);
        logic acc;
        li.in_req   = req;
        li.in_we    = we;
        li.in_addr  = a;
        li.in_wdata = d;
        li.in_wstrb = s;
        mi.mem_gnt  = gnt;
        #1;
        chk("in_gnt", li.in_gnt, occ < DEPTH);
        chk("busy", busy, occ > 0);
        chk("words_written", words_written, exp_words);
        chk("overflow", overflow, exp_ovf);
        chk("mem_we", mi.mem_we, 1'b1);
        if (mi.mem_req) begin
            if (exp_q.size() == 0) chk("spurious_mem_req", mi.mem_req, 1'b0);
            else chk("beat{addr,data,strb}", {mi.mem_addr, mi.mem_wdata, mi.mem_wstrb},
                     {exp_q[0].a, exp_q[0].d, exp_q[0].s});
        end
        acc = mi.mem_req && gnt;
        @(posedge clk);
        if (req && we) begin
            if (occ < DEPTH) begin
                model_push(a, d, s);
                occ++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        if (acc && exp_q.size() > 0) begin
            beat_t b;
            b = exp_q.pop_front();
            beats_done++;
            if (b.last) begin
                occ--;
                exp_words = exp_words + 32'd1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_cyc(input logic gnt);
        cyc(1'b0, 1'b0, 32'h0, 128'h0, 16'h0, gnt);
    endtask

    task automatic drain(input int maxc);
        for (int i = 0; i < maxc && occ > 0; i++) idle_cyc(1'b1);
        chk("drain_timeout", occ, 0);
        idle_cyc(1'b1);
        idle_cyc(1'b1);
        chk("beats_left", exp_q.size(), 0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [15:0] strb;
        int          n;
        logic [31:0] a0;
        logic [31:0] d0;
        logic [3:0]  s0;
    } vec_t;

    localparam logic [127:0] PAT = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    initial begin
        vec_t        tv[7];
        int          n, b0, stall;
        logic [31:0] fa, fd;
        logic [3:0]  fs;
        logic        g;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        set_idle();
        mi.mem_gnt = 1'b0;
        model_clear();

        tv[0] = '{32'h0000_0013, 16'h0F00, 1, 32'h8000_0018, 32'h33333333, 4'hF};
        tv[1] = '{32'h0000_0100, 16'hFFFF, 4, 32'h8000_0100, 32'h11111111, 4'hF};
        tv[2] = '{32'h0000_0200, 16'h8001, 2, 32'h8000_0200, 32'h11111111, 4'h1};
        tv[3] = '{32'h0000_030C, 16'h00F0, 1, 32'h8000_0304, 32'h22222222, 4'hF};
        tv[4] = '{32'hFFFF_FFFF, 16'hF000, 1, 32'h7FFF_FFFC, 32'h44444444, 4'hF};
        tv[5] = '{32'h0000_0040, 16'h0000, 0, 32'h0,         32'h0,        4'h0};
        tv[6] = '{32'h0000_0050, 16'h0360, 2, 32'h8000_0054, 32'h22222222, 4'h6};

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_mem_req", mi.mem_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_gnt", li.in_gnt, 1'b1);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_words", words_written, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: single line, memory always granting
        for (int v = 0; v < 7; v++) begin
            reset_dut();
            mi.mem_gnt  = 1'b1;
            li.in_req   = 1'b1;
            li.in_we    = 1'b1;
            li.in_addr  = tv[v].addr;
            li.in_wdata = PAT;
            li.in_wstrb = tv[v].strb;
            @(posedge clk);
            @(negedge clk);
            set_idle();
            n  = 0;
            fa = '0;
            fd = '0;
            fs = '0;
            for (int c = 0; c < 12; c++) begin
                #1;
                if (mi.mem_req && mi.mem_gnt) begin
                    if (n == 0) begin
                        fa = mi.mem_addr;
                        fd = mi.mem_wdata;
                        fs = mi.mem_wstrb;
                    end
                    n++;
                end
                @(posedge clk);
                @(negedge clk);
            end
            chk($sformatf("vec%0d_nbeats", v), n, tv[v].n);
            chk($sformatf("vec%0d_first_addr", v), fa, tv[v].a0);
            chk($sformatf("vec%0d_first_data", v), fd, tv[v].d0);
            chk($sformatf("vec%0d_first_strb", v), fs, tv[v].s0);
            chk($sformatf("vec%0d_words", v), words_written, 32'd1);
            chk($sformatf("vec%0d_busy", v), busy, 1'b0);
        end

        // Latency: accepted at edge T, mem_req visible only after edge T+1
        reset_dut();
        cyc(1'b1, 1'b1, 32'h100, PAT, 16'hFFFF, 1'b1);
        #1;
        chk("lat_before", mi.mem_req, 1'b0);
        idle_cyc(1'b1);
        #1;
        chk("lat_after", mi.mem_req, 1'b1);
        drain(20);
        chk("t1_words", words_written, 32'd1);

        // Requests with in_we=0 are ignored
        reset_dut();
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'h100, PAT, 16'hFFFF, 1'b0);
        chk("we0_ovf", overflow, 1'b0);
        chk("we0_busy", busy, 1'b0);

        // Stall on beat 1: held values are checked every cycle by the model
        reset_dut();
        cyc(1'b1, 1'b1, 32'h100, PAT, 16'hFFFF, 1'b1);
        stall = 0;
        for (int c = 0; c < 30 && occ > 0; c++) begin
            if (beats_done == 1 && mi.mem_req && stall < 5) begin
                g = 1'b0;
                stall++;
            end else begin
                g = 1'b1;
            end
            cyc(1'b0, 1'b0, 32'h0, 128'h0, 16'h0, g);
        end
        drain(10);
        chk("t2_stall_cycles", stall, 5);
        chk("t2_beats", beats_done, 4);

        // Fill with memory stalled, drop the fifth, then release
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                #1;
                chk("t3_full_gnt", li.in_gnt, 1'b0);
            end
            cyc(1'b1, 1'b1, 32'h400 + 32'(16 * i), rand128(), 16'hFFFF, 1'b0);
        end
        #1;
        chk("t3_ovf_set", overflow, 1'b1);
        drain(60);
        chk("t3_beats", beats_done, 16);
        chk("t3_words", words_written, 32'd4);
        chk("t3_ovf_sticky", overflow, 1'b1);

        // Back-to-back pushes, then one more while draining
        reset_dut();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'h200 + 32'(16 * i), rand128(), 16'hFFFF, 1'b1);
        idle_cyc(1'b1);
        idle_cyc(1'b1);
        cyc(1'b1, 1'b1, 32'h230, rand128(), 16'hFFFF, 1'b1);
        drain(60);
        chk("t5_beats", beats_done, 16);
        chk("t5_words", words_written, 32'd4);

        // Reset during the second beat of a line
        reset_dut();
        cyc(1'b1, 1'b1, 32'h100, PAT, 16'hFFFF, 1'b1);
        for (int c = 0; c < 10 && beats_done < 1; c++) idle_cyc(1'b1);
        #1;
        chk("t6_on_beat1", mi.mem_addr, TB_BASE + 32'h104);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_req_off", mi.mem_req, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_words", words_written, 32'd0);
        chk("t6_ovf", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < 4; i++) idle_cyc(1'b1);
        cyc(1'b1, 1'b1, 32'h300, rand128(), 16'hFFFF, 1'b1);
        drain(20);
        chk("t6_after_words", words_written, 32'd1);

        // Randomized traffic against the model
        reset_dut();
        for (int c = 0; c < 800; c++) begin
            logic [15:0] s;
            s = 16'($urandom);
            if (s == 16'h0) s = 16'h0001;
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                $urandom, rand128(), s, $urandom_range(0, 2) != 0);
        end
        b0 = beats_done;
        drain(100);
        chk("rand_progress", beats_done > b0 || b0 > 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prog_mem_writer.md
Name: prog_mem_writer

Overview:
Downstream write adapter for the UART boot programmer. It accepts 128-bit line writes (addr, data, 16-bit strobe) on a req/gnt port and buffers them in a small FIFO. It then drains each line as up to four 32-bit beats onto a narrow req/gnt memory port. It decouples the programmer, which pulses its request without waiting for a grant, from a slow or stalling memory, and it flags any write that is lost.

Parameters:
FIFO_DEPTH, 4, number of 128-bit entries; power of two, at least 2.
ADDR_BASE, 32'h0000_0000, offset added to every incoming line address (modulo 2^32).

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
in_req  input  1  line write request (single-cycle pulses allowed)
in_gnt  output  1  combinational, equals !fifo_full
in_we  input  1  write enable; requests with in_we=0 are ignored
in_addr  input  32  line byte address; bits [3:0] ignored (treated as 0)
in_wdata  input  128  line data; word k = in_wdata[32k+:32]
in_wstrb  input  16  byte strobes; word k strobe = in_wstrb[4k+:4]
mem_req  output  1  beat request
mem_gnt  input  1  beat accepted when mem_req && mem_gnt
mem_we  output  1  constant 1
mem_addr  output  32  beat byte address
mem_wdata  output  32  beat data
mem_wstrb  output  4  beat byte strobes
busy  output  1  high when FIFO is non-empty or FSM is not IDLE
overflow  output  1  sticky; set when a write was dropped
words_written  output  32  count of fully drained lines, wraps at 2^32

Behaviour:
- Reset (rst_n=0 at a clk edge): FIFO emptied, FSM to IDLE, beat counter=0, overflow=0, words_written=0. On the following cycle: mem_req=0, busy=0, in_gnt=1. mem_addr, mem_wdata and mem_wstrb are don't-care while mem_req=0. mem_we=1 always. A reset in mid-beat abandons that beat; no further memory requests are issued.
- Push: when in_req && in_we && in_gnt, store {ADDR_BASE + {in_addr[31:4],4'h0}, in_wdata, in_wstrb} at the FIFO tail on that edge.
- Drop: when in_req && in_we && full, nothing is stored and overflow is set. A request with in_we=0 is neither stored nor counted as a drop.
- No bypass: a push into a full FIFO is not stored even if the FIFO pops on the same cycle. A push into an empty FIFO does not reach the memory port on the same cycle. Simultaneous push and pop on a non-full FIFO is legal and leaves the occupancy unchanged.
- FSM states: IDLE and ISSUE.
  - IDLE to ISSUE at the edge when the FIFO is non-empty. Beat counter k is then loaded with the lowest k whose strobe nibble is non-zero.
  - A head entry with in_wstrb==0 is popped directly from IDLE, taking one cycle. It increments words_written and issues no beat.
- ISSUE: mem_req=1. mem_addr = head.addr + 4k, mem_wdata = head.data[32k+:32], mem_wstrb = head.strb[4k+:4]. All of these are held stable until mem_gnt.
  - On mem_req && mem_gnt, k advances to the next higher index with a non-zero strobe nibble, and mem_req stays high with no bubble.
  - If no such index exists, the head is popped, words_written is incremented, and the FSM goes to IDLE.
- Timing:
  - Acceptance at edge T gives mem_req high in the cycle after edge T+1.
  - With mem_gnt tied high, a full-strobe line takes 4 beat cycles, plus 1 IDLE cycle before the next line.
- busy is combinational from FIFO occupancy and FSM state.

Test Plan:
1. FIFO_DEPTH=4, mem_gnt=1, one push: addr 0x100, data {32'h44444444,32'h33333333,32'h22222222,32'h11111111}, strobe 16'hFFFF -> four beats to 0x100/0x104/0x108/0x10C with data 0x11111111, 0x22222222, 0x33333333, 0x44444444, strobe 4'hF each; words_written=1; busy falls afterwards.
2. Same push with mem_gnt low for 5 cycles on beat 1 -> mem_req, mem_addr=0x104 and mem_wdata held constant throughout the stall; beat order and count unchanged.
3. mem_gnt=0, five consecutive single-cycle pushes -> in_gnt=0 after the 4th push; 5th dropped and overflow=1. On release, exactly 4 lines (16 beats) drain in push order; words_written=4; overflow stays 1.
4. Strobe 16'h0F00, ADDR_BASE=32'h8000_0000, in_addr 0x13 -> one beat, addr 0x8000_0018, strobe 4'hF. Strobe 16'h0000 -> no beats, words_written still increments.
5. Three back-to-back pushes with mem_gnt=1 -> 12 beats with addresses contiguous across lines and no lost data; push during drain is accepted while not full.
6. rst_n low during the 2nd beat of a line -> mem_req=0 the next cycle, FIFO empty, overflow=0, words_written=0. A subsequent push drains normally from beat 0.
